// File: rtl/strobe_period_gen.sv
// Programmable period strobe source: one-cycle strobe every cur_div cycles, phase index,
// strobe count, and a boundary-aligned divisor load/ack handshake. Optional macro: STROBE_CNT_SAT_EN.
module strobe_period_gen #(
  parameter int unsigned DIV_RST = 4,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic [7:0]       div_val,
  input  logic             div_load,
  output logic             div_ack,
  output logic             strobe,
  output logic [7:0]       phase,
  output logic [CNT_W-1:0] strobe_cnt,
  output logic [7:0]       cur_div
);

  localparam int unsigned DIV_W = 8;
  localparam logic [DIV_W-1:0] DIV_INIT = DIV_W'(DIV_RST);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state;
  logic               pending;
  logic [DIV_W-1:0]   pend_div;

  logic               count_c;
  logic               wrap_c;
  logic [DIV_W-1:0]   load_div_c;
  logic [CNT_W-1:0]   cnt_next_c;

  // Per-edge decode: whether this edge counts, period boundary, clamped request, next count.
  always_comb begin
    count_c    = 1'b0;
    wrap_c     = (phase == (cur_div - DIV_W'(1)));
    load_div_c = (div_val == '0) ? DIV_W'(1) : div_val;
`ifdef STROBE_CNT_SAT_EN
    cnt_next_c = (strobe_cnt == '1) ? strobe_cnt : strobe_cnt + CNT_W'(1);
`else
    cnt_next_c = strobe_cnt + CNT_W'(1);
`endif
    case (state)
      IDLE:    count_c = en;
      RUN:     count_c = en;
      default: count_c = 1'b0;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state      <= IDLE;
      phase      <= '0;
      strobe     <= 1'b0;
      div_ack    <= 1'b0;
      strobe_cnt <= '0;
      cur_div    <= DIV_INIT;
      pending    <= 1'b0;
      pend_div   <= '0;
    end else begin
      state   <= en ? RUN : IDLE;
      strobe  <= 1'b0;
      div_ack <= 1'b0;
      if (count_c) begin
        if (wrap_c) begin
          phase      <= '0;
          strobe     <= 1'b1;
          strobe_cnt <= cnt_next_c;
          if (pending) begin
            cur_div <= pend_div;
            pending <= 1'b0;
            div_ack <= 1'b1;
          end
        end else begin
          phase <= phase + DIV_W'(1);
        end
      end
      // Placed after the apply so a load on a wrap edge stays pending for the next wrap.
      if (div_load) begin
        pend_div <= load_div_c;
        pending  <= 1'b1;
      end
    end
  end

endmodule

// File: doc/strobe_period_gen.md
Name: strobe_period_gen

Overview:
- Programmable strobe source. Produces a single-cycle strobe every N clock cycles, plus a running phase index and an 8-bit strobe count.
- Sits directly upstream of the clock-strobe/pulse stages in the clock-divider project and supplies their periodic enable.
- The divisor can be changed at run time through a load/ack handshake. A change takes effect only on a period boundary, so no runt or stretched period is ever produced.

Parameters:
- DIV_RST, 4: divisor loaded into the active divisor at reset (1..255).
- CNT_W, 8: width of strobe_cnt.

Ports:
- clk_in  in  1  single system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  run enable; low freezes the phase counter.
- div_val  in  8  requested divisor; 0 is treated as 1.
- div_load  in  1  one-cycle request that captures div_val as the pending divisor.
- div_ack  out  1  one-cycle pulse on the edge where a pending divisor becomes active.
- strobe  out  1  registered one-cycle pulse, one per period.
- phase  out  8  current position in the period, 0..cur_div-1.
- strobe_cnt  out  CNT_W  number of strobes issued, modulo 2^CNT_W.
- cur_div  out  8  active divisor, for observation.

Behaviour:
- Reset (rst high at an edge): phase=0, strobe=0, div_ack=0, strobe_cnt=0, cur_div=DIV_RST, pending flag=0, pend_div=0, state=IDLE. rst has priority over every other input.
- State machine:
  - IDLE: entered at reset or when en=0 is sampled. No increments, strobe=0.
  - IDLE -> RUN on the edge where en=1 is sampled. That edge already counts.
  - RUN -> IDLE on any edge where en=0 is sampled.
- Counting, on each edge with en=1:
  - If phase==cur_div-1 (a wrap): phase<=0, strobe<=1, strobe_cnt<=strobe_cnt+1.
  - Otherwise: phase<=phase+1, strobe<=0.
  - strobe is therefore high in the same cycle that phase reads 0 after a wrap.
- Timing from reset release with en held high: first strobe after exactly cur_div edges, then every cur_div cycles.
- cur_div=1: strobe high every cycle, phase stays 0.
- en low mid-period: phase holds its value, strobe<=0, strobe_cnt holds. On re-enable, counting resumes from the held phase; the period is not restarted.
- Divisor handshake:
  - div_load=1 at an edge: pend_div<=max(div_val,1), pending<=1.
  - A later div_load before apply overwrites pend_div (last write wins).
  - Apply happens only on a wrap edge with pending=1: cur_div<=pend_div, pending<=0, div_ack<=1 for one cycle. div_ack is 0 otherwise.
  - The new divisor governs the period that begins at that wrap.
  - div_load on the same edge as a wrap: the new value becomes pending. It is applied at the next wrap, never at the current one. Any older pending value is applied at the current wrap if it existed, and the new one stays pending.
  - Pending is held indefinitely while en=0.
- strobe_cnt wraps from 2^CNT_W-1 to 0 with no flag.
- Reset mid-period or mid-handshake: pending request discarded, no div_ack, cur_div returns to DIV_RST.

Optional Feature:
- Macro STROBE_CNT_SAT_EN.
- Defined: strobe_cnt saturates at 2^CNT_W-1 and holds there until reset; strobe itself is unaffected.
- Undefined: strobe_cnt wraps modulo 2^CNT_W as above.

Test Plan:
- Reset then en=1 for 12 cycles, DIV_RST=4 -> strobe high on cycles 4, 8, 12 after release; phase sequence 1,2,3,0,...; strobe_cnt=3.
- div_val=6 with div_load pulsed at phase=1 -> div_ack and cur_div=6 at the next wrap. The following strobes are spaced 6 cycles apart, and the period in progress stays 4 cycles.
- div_load with div_val=0 -> cur_div=1 after the next wrap; strobe high every cycle; div_load of 3 then 5 in consecutive cycles -> only 5 applied, single div_ack.
- en dropped at phase=2 for 7 cycles -> phase holds at 2, no strobe. After en returns, the next strobe comes 2 cycles later.
- Run with cur_div=1 for 260 cycles -> strobe_cnt=4 (wrapped) without the macro, and 255 with STROBE_CNT_SAT_EN.
- rst asserted one cycle after div_load while pending -> no div_ack ever, cur_div=4, all outputs 0 on the next cycle.
